// File: rtl/zone_palette_painter_if.sv
// rtl/zone_palette_painter_if.sv - control and pixel bus between VGA timing, painter and DAC stage
interface zone_palette_painter_if #(
  parameter int COLOR_W = 24,
  parameter int IDX_W   = 2
);
  logic               swap_in;
  logic               mode_in;
  logic               frame_start_in;
  logic [9:0]         horizontal;
  logic [9:0]         vertical;
  logic [COLOR_W-1:0] color;
  logic [IDX_W-1:0]   load_idx;

  modport master (
    output swap_in, mode_in, frame_start_in, horizontal, vertical,
    input  color, load_idx
  );

  modport slave (
    input  swap_in, mode_in, frame_start_in, horizontal, vertical,
    output color, load_idx
  );
endinterface

// File: rtl/zone_palette_painter.sv
// rtl/zone_palette_painter.sv - grid-zoned palette painter with manual load and auto-rotate
module zone_palette_painter #(
  parameter int COLOR_W    = 24,
  parameter int NUM_ZONES  = 4,
  parameter int ZONE_COLS  = 2,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int COLOR_STEP = 1,
  parameter int ROT_FRAMES = 60
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  zone_palette_painter_if.slave   bus
);

  localparam int ZONE_ROWS = NUM_ZONES / ZONE_COLS;
  localparam int IDX_W     = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam int FRM_W     = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
  localparam int COL_PITCH = H_ACTIVE / ZONE_COLS;
  localparam int ROW_PITCH = V_ACTIVE / ZONE_ROWS;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ZONES - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(ROT_FRAMES - 1);

  logic [COLOR_W-1:0] gen_q, gen_d;
  logic               swap_s1_q, swap_s2_q, swap_s3_q;
  logic [COLOR_W-1:0] pal_q [NUM_ZONES];
  logic [COLOR_W-1:0] pal_d [NUM_ZONES];
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRM_W-1:0]   frm_q, frm_d;
  logic [COLOR_W-1:0] color_q, color_d;

  logic               swap_pulse;
  logic [31:0]        col_cnt;
  logic [31:0]        row_cnt;
  logic [IDX_W-1:0]   zone;
  logic               in_active;

  // The swap button is asynchronous: two flops resynchronise it, the third marks the rising edge.
  assign swap_pulse = swap_s2_q & ~swap_s3_q;

  // Free-running colour generator, wraps naturally at 2^COLOR_W.
  assign gen_d = gen_q + COLOR_W'(COLOR_STEP);

  // Palette, load pointer and frame counter next state; manual writes and rotations are mutually exclusive by mode.
  always_comb begin
    pal_d = pal_q;
    idx_d = idx_q;
    frm_d = frm_q;
    if (!bus.mode_in) begin
      frm_d = '0;
      if (swap_pulse) begin
        pal_d[idx_q] = gen_q;
        idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end else if (bus.frame_start_in) begin
      if (frm_q == FRM_LAST) begin
        frm_d = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
          pal_d[i] = pal_q[(i + 1) % NUM_ZONES];
        end
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // Zone decode by counting crossed boundaries, so no divider is needed.
  always_comb begin
    col_cnt = '0;
    row_cnt = '0;
    for (int k = 1; k < ZONE_COLS; k++) begin
      if ({22'd0, bus.horizontal} >= 32'(k * COL_PITCH)) begin
        col_cnt = col_cnt + 32'd1;
      end
    end
    for (int k = 1; k < ZONE_ROWS; k++) begin
      if ({22'd0, bus.vertical} >= 32'(k * ROW_PITCH)) begin
        row_cnt = row_cnt + 32'd1;
      end
    end
  end

  assign zone      = IDX_W'(row_cnt * 32'(ZONE_COLS) + col_cnt);
  assign in_active = ({22'd0, bus.horizontal} < 32'(H_ACTIVE)) &&
                     ({22'd0, bus.vertical}   < 32'(V_ACTIVE));

  // Output colour reads the current palette, so a same-edge write shows up one pixel later.
  assign color_d = in_active ? pal_q[zone] : '0;

  // Swap synchroniser and edge-detect flops.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      swap_s1_q <= 1'b0;
      swap_s2_q <= 1'b0;
      swap_s3_q <= 1'b0;
    end else begin
      swap_s1_q <= bus.swap_in;
      swap_s2_q <= swap_s1_q;
      swap_s3_q <= swap_s2_q;
    end
  end

  // Generator, palette, pointers and registered pixel output.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      gen_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      color_q <= '0;
      for (int i = 0; i < NUM_ZONES; i++) begin
        pal_q[i] <= '0;
      end
    end else begin
      gen_q   <= gen_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      color_q <= color_d;
      for (int i = 0; i < NUM_ZONES; i++) begin
        pal_q[i] <= pal_d[i];
      end
    end
  end

  assign bus.color    = color_q;
  assign bus.load_idx = idx_q;

endmodule

// File: tb/tb_zone_palette_painter.sv
// tb/tb_zone_palette_painter.sv - randomized directed bench for zone_palette_painter against a queue model
module tb_zone_palette_painter;

  localparam int ROT = 2;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b0;

  zone_palette_painter_if #(.COLOR_W(24), .IDX_W(2)) bus4 ();
  zone_palette_painter_if #(.COLOR_W(24), .IDX_W(3)) bus8 ();

  zone_palette_painter #(
    .COLOR_W(24), .NUM_ZONES(4), .ZONE_COLS(2), .H_ACTIVE(640), .V_ACTIVE(480),
    .COLOR_STEP(1), .ROT_FRAMES(ROT)
  ) dut4 (.clk_in(clk_in), .reset_in(reset_in), .bus(bus4));

  zone_palette_painter #(
    .COLOR_W(24), .NUM_ZONES(8), .ZONE_COLS(4), .H_ACTIVE(640), .V_ACTIVE(480),
    .COLOR_STEP(1), .ROT_FRAMES(ROT)
  ) dut8 (.clk_in(clk_in), .reset_in(reset_in), .bus(bus8));

  always #5 clk_in = ~clk_in;

  int edge_cnt;
  always @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) edge_cnt <= 0;
    else           edge_cnt <= edge_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] m4[$];
  logic [23:0] m8[$];
  int i4, i8, fc;
  logic mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m4.delete();
    m8.delete();
    repeat (4) m4.push_back(24'd0);
    repeat (8) m8.push_back(24'd0);
    i4 = 0;
    i8 = 0;
    fc = 0;
  endtask

  function automatic logic [23:0] exp_col(int h, int v, bit big);
    int cols, z;
    cols = big ? 4 : 2;
    if (h >= 640 || v >= 480) return 24'd0;
    z = (v / 240) * cols + h / (640 / cols);
    return big ? m8[z] : m4[z];
  endfunction

  task automatic drive_xy(int h, int v);
    bus4.horizontal = 10'(h);
    bus8.horizontal = 10'(h);
    bus4.vertical   = 10'(v);
    bus8.vertical   = 10'(v);
  endtask

  task automatic check_xy(string tag, int h, int v);
    drive_xy(h, v);
    @(negedge clk_in);
    chk($sformatf("%s_z4_%0d_%0d", tag, h, v), bus4.color, exp_col(h, v, 1'b0));
    chk($sformatf("%s_z8_%0d_%0d", tag, h, v), bus8.color, exp_col(h, v, 1'b1));
  endtask

  task automatic check_all(string tag);
    for (int z = 0; z < 8; z++) check_xy(tag, (z % 4) * 160 + 80, (z / 4) * 240 + 120);
  endtask

  task automatic check_idx(string tag);
    chk({tag, "_idx4"}, bus4.load_idx, i4);
    chk({tag, "_idx8"}, bus8.load_idx, i8);
  endtask

  task automatic set_swap(logic s);
    bus4.swap_in = s;
    bus8.swap_in = s;
  endtask

  task automatic set_mode(logic m);
    mode = m;
    bus4.mode_in = m;
    bus8.mode_in = m;
    if (!m) fc = 0;
  endtask

  task automatic model_write(logic [23:0] val);
    m4[i4] = val;
    m8[i8] = val;
    i4 = (i4 + 1) % 4;
    i8 = (i8 + 1) % 8;
  endtask

  // Raise the button at a negedge; the write lands two edges after the next one.
  task automatic do_swap(int hold);
    logic [23:0] val;
    val = 24'(edge_cnt + 2);
    set_swap(1'b1);
    if (!mode) model_write(val);
    repeat (hold) @(negedge clk_in);
    set_swap(1'b0);
    repeat (4) @(negedge clk_in);
  endtask

  task automatic frame_pulse();
    bus4.frame_start_in = 1'b1;
    bus8.frame_start_in = 1'b1;
    @(negedge clk_in);
    bus4.frame_start_in = 1'b0;
    bus8.frame_start_in = 1'b0;
    if (mode) begin
      fc++;
      if (fc == ROT) begin
        fc = 0;
        m4.push_back(m4.pop_front());
        m8.push_back(m8.pop_front());
      end
    end
    repeat ($urandom_range(1, 3)) @(negedge clk_in);
  endtask

  int xy_h[9] = '{0, 320, 0, 639, 640, 0, 319, 160, 480};
  int xy_v[9] = '{0, 0, 240, 479, 0, 480, 239, 0, 240};
  logic [23:0] old4, old8, nv;

  initial begin
    reset_model();
    set_swap(1'b0);
    set_mode(1'b0);
    bus4.frame_start_in = 1'b0;
    bus8.frame_start_in = 1'b0;
    drive_xy(0, 0);

    repeat (3) @(negedge clk_in);
    chk("rst_color4", bus4.color, 0);
    chk("rst_color8", bus8.color, 0);
    check_idx("rst");
    reset_in = 1'b1;
    check_all("post_rst");

    for (int n = 0; n < 8; n++) begin
      do_swap($urandom_range(1, 8));
      repeat ($urandom_range(0, 6)) @(negedge clk_in);
      check_idx($sformatf("swap%0d", n));
    end

    check_all("loaded");
    for (int n = 0; n < 9; n++) check_xy("grid", xy_h[n], xy_v[n]);
    for (int n = 0; n < 12; n++) check_xy("rand", $urandom_range(0, 700), $urandom_range(0, 520));

    drive_xy(0, 0);
    @(negedge clk_in);
    old4 = m4[0];
    old8 = m8[0];
    nv   = 24'(edge_cnt + 2);
    set_swap(1'b1);
    repeat (3) @(negedge clk_in);
    chk("coll_old4", bus4.color, old4);
    chk("coll_old8", bus8.color, old8);
    @(negedge clk_in);
    chk("coll_new4", bus4.color, nv);
    chk("coll_new8", bus8.color, nv);
    model_write(nv);
    set_swap(1'b0);
    repeat (4) @(negedge clk_in);
    check_idx("coll");

    frame_pulse();
    frame_pulse();
    check_all("manual_frames");

    do_swap(100);
    check_idx("held");
    check_all("held");

    set_mode(1'b1);
    do_swap(3);
    do_swap($urandom_range(1, 5));
    check_idx("auto_swap");
    frame_pulse();
    frame_pulse();
    check_all("rot1");
    frame_pulse();
    @(negedge clk_in);
    set_mode(1'b0);
    @(negedge clk_in);
    set_mode(1'b1);
    @(negedge clk_in);
    frame_pulse();
    check_all("cnt_cleared");
    frame_pulse();
    check_all("rot2");

    set_swap(1'b1);
    repeat (5) @(negedge clk_in);
    set_mode(1'b0);
    repeat (3) @(negedge clk_in);
    set_swap(1'b0);
    repeat (4) @(negedge clk_in);
    check_idx("auto_then_manual");
    check_all("auto_then_manual");

    do_swap(2);
    drive_xy(0, 0);
    @(negedge clk_in);
    #2 reset_in = 1'b0;
    #1;
    chk("midrst_color4", bus4.color, 0);
    chk("midrst_color8", bus8.color, 0);
    chk("midrst_idx4", bus4.load_idx, 0);
    chk("midrst_idx8", bus8.load_idx, 0);
    reset_model();
    @(negedge clk_in);
    reset_in = 1'b1;
    check_all("after_midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
